// File: rtl/rmt_xbar_pipe.sv
// Operand crossbar for one RMT action stage: unpacks PHV containers, decodes one action
// per container, and registers the operand bundle behind a 1-entry skid buffer. Optional macro: XBAR_IDX_ERR_EN.
module rmt_xbar_pipe #(
  parameter int STAGE_ID = 0,
  parameter int NUM_6B   = 8,
  parameter int NUM_4B   = 8,
  parameter int NUM_2B   = 8,
  parameter int W6       = 48,
  parameter int W4       = 32,
  parameter int W2       = 16,
  parameter int META_LEN = 256,
  parameter int ACT_LEN  = 25,
  parameter int VLAN_LSB = 129,
  localparam int PHV_LEN = NUM_6B*W6 + NUM_4B*W4 + NUM_2B*W2 + META_LEN,
  localparam int NUM_ACT = NUM_6B + NUM_4B + NUM_2B + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PHV_LEN-1:0]         in_phv,
  input  logic [NUM_ACT*ACT_LEN-1:0] in_act,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_6B*W6-1:0]       out_6b_a,
  output logic [NUM_6B*W6-1:0]       out_6b_b,
  output logic [NUM_4B*W4-1:0]       out_4b_a,
  output logic [NUM_4B*W4-1:0]       out_4b_b,
  output logic [NUM_4B*W4-1:0]       out_4b_c,
  output logic [NUM_2B*W2-1:0]       out_2b_a,
  output logic [NUM_2B*W2-1:0]       out_2b_b,
  output logic [META_LEN-1:0]        out_meta,
  output logic [NUM_ACT*ACT_LEN-1:0] out_act,
  output logic [11:0]                vlan_id
`ifdef XBAR_IDX_ERR_EN
  ,
  output logic [15:0]                idx_err_cnt,
  output logic [0:0]                 idx_err
`endif
);

  localparam int OFF2 = META_LEN;
  localparam int OFF4 = OFF2 + NUM_2B*W2;
  localparam int OFF6 = OFF4 + NUM_4B*W4;
  localparam int S2   = 1;
  localparam int S4   = NUM_2B + 1;
  localparam int S6   = NUM_2B + NUM_4B + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_6B*W6-1:0]       a6;
    logic [NUM_6B*W6-1:0]       b6;
    logic [NUM_4B*W4-1:0]       a4;
    logic [NUM_4B*W4-1:0]       b4;
    logic [NUM_4B*W4-1:0]       c4;
    logic [NUM_2B*W2-1:0]       a2;
    logic [NUM_2B*W2-1:0]       b2;
    logic [META_LEN-1:0]        meta;
    logic [NUM_ACT*ACT_LEN-1:0] act;
  } bundle_t;

  // Index selects beyond the populated containers fall through to zero.
  function automatic logic [W6-1:0] pick6(input logic [NUM_6B*W6-1:0] flat, input logic [2:0] idx);
    logic [W6-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_6B; j++) r = (idx == 3'(j)) ? flat[j*W6 +: W6] : r;
    return r;
  endfunction

  function automatic logic [W4-1:0] pick4(input logic [NUM_4B*W4-1:0] flat, input logic [2:0] idx);
    logic [W4-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_4B; j++) r = (idx == 3'(j)) ? flat[j*W4 +: W4] : r;
    return r;
  endfunction

  function automatic logic [W2-1:0] pick2(input logic [NUM_2B*W2-1:0] flat, input logic [2:0] idx);
    logic [W2-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_2B; j++) r = (idx == 3'(j)) ? flat[j*W2 +: W2] : r;
    return r;
  endfunction

  logic [NUM_6B*W6-1:0] c6_s;
  logic [NUM_4B*W4-1:0] c4_s;
  logic [NUM_2B*W2-1:0] c2_s;
  bundle_t              nxt_s;
  bundle_t              out_r;
  bundle_t              skid_r;
  state_t               state_r;
  state_t               nstate_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [11:0]          vlan_r;
  logic                 acc_s;
  logic                 emit_s;
  logic                 load_new_s;
  logic                 load_skid_s;
  logic                 load_skid_out_s;
  logic                 unused_s;

  assign c6_s = in_phv[OFF6 +: NUM_6B*W6];
  assign c4_s = in_phv[OFF4 +: NUM_4B*W4];
  assign c2_s = in_phv[OFF2 +: NUM_2B*W2];
  assign unused_s = ^{in_act, 32'(STAGE_ID)};

  // Per-container operand decode of the incoming PHV/action pair
  always_comb begin
    logic [ACT_LEN-1:0] s;
    nxt_s      = '0;
    s          = '0;
    nxt_s.meta = in_phv[META_LEN-1:0];
    nxt_s.act  = in_act;
    for (int i = 0; i < NUM_6B; i++) begin
      s = in_act[(S6+i)*ACT_LEN +: ACT_LEN];
      case (s[24:21])
        4'b0001, 4'b0010: begin
          nxt_s.a6[i*W6 +: W6] = pick6(c6_s, s[18:16]);
          nxt_s.b6[i*W6 +: W6] = pick6(c6_s, s[13:11]);
        end
        4'b1001, 4'b1010: begin
          nxt_s.a6[i*W6 +: W6] = pick6(c6_s, s[18:16]);
          nxt_s.b6[i*W6 +: W6] = W6'(s[15:0]);
        end
        4'b1110: begin
          nxt_s.a6[i*W6 +: W6] = '0;
          nxt_s.b6[i*W6 +: W6] = W6'(s[15:0]);
        end
        default: begin
          nxt_s.a6[i*W6 +: W6] = c6_s[i*W6 +: W6];
          nxt_s.b6[i*W6 +: W6] = '0;
        end
      endcase
    end
    for (int i = 0; i < NUM_4B; i++) begin
      s = in_act[(S4+i)*ACT_LEN +: ACT_LEN];
      nxt_s.c4[i*W4 +: W4] = c4_s[i*W4 +: W4];
      case (s[24:21])
        4'b0001, 4'b0010, 4'b1011, 4'b1000, 4'b0111: begin
          nxt_s.a4[i*W4 +: W4] = pick4(c4_s, s[18:16]);
          nxt_s.b4[i*W4 +: W4] = pick4(c4_s, s[13:11]);
        end
        4'b1001, 4'b1010: begin
          nxt_s.a4[i*W4 +: W4] = pick4(c4_s, s[18:16]);
          nxt_s.b4[i*W4 +: W4] = W4'(s[15:0]);
        end
        4'b1110: begin
          nxt_s.a4[i*W4 +: W4] = '0;
          nxt_s.b4[i*W4 +: W4] = W4'(s[15:0]);
        end
        default: begin
          nxt_s.a4[i*W4 +: W4] = c4_s[i*W4 +: W4];
          nxt_s.b4[i*W4 +: W4] = '0;
        end
      endcase
    end
    for (int i = 0; i < NUM_2B; i++) begin
      s = in_act[(S2+i)*ACT_LEN +: ACT_LEN];
      case (s[24:21])
        4'b0001, 4'b0010: begin
          nxt_s.a2[i*W2 +: W2] = pick2(c2_s, s[18:16]);
          nxt_s.b2[i*W2 +: W2] = pick2(c2_s, s[13:11]);
        end
        4'b1001, 4'b1010: begin
          nxt_s.a2[i*W2 +: W2] = pick2(c2_s, s[18:16]);
          nxt_s.b2[i*W2 +: W2] = W2'(s[15:0]);
        end
        4'b1110: begin
          nxt_s.a2[i*W2 +: W2] = '0;
          nxt_s.b2[i*W2 +: W2] = W2'(s[15:0]);
        end
        default: begin
          nxt_s.a2[i*W2 +: W2] = c2_s[i*W2 +: W2];
          nxt_s.b2[i*W2 +: W2] = '0;
        end
      endcase
    end
  end

  assign acc_s           = in_valid & in_ready_r;
  assign emit_s          = out_valid_r & out_ready;
  assign load_new_s      = acc_s & ((state_r == ST_EMPTY) | ((state_r == ST_ONE) & emit_s));
  assign load_skid_s     = acc_s & (state_r == ST_ONE) & ~emit_s;
  assign load_skid_out_s = (state_r == ST_FULL) & emit_s;

  // Skid-buffer next-state selection
  always_comb begin
    nstate_s = state_r;
    case (state_r)
      ST_EMPTY: nstate_s = acc_s ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (acc_s && !emit_s) begin
          nstate_s = ST_FULL;
        end else if (!acc_s && emit_s) begin
          nstate_s = ST_EMPTY;
        end else begin
          nstate_s = ST_ONE;
        end
      end
      ST_FULL:  nstate_s = emit_s ? ST_ONE : ST_FULL;
      default:  nstate_s = ST_EMPTY;
    endcase
  end

  // State, handshake flags, output/skid bundles and captured VLAN id
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      skid_r      <= '0;
      vlan_r      <= 12'd0;
    end else begin
      state_r     <= nstate_s;
      in_ready_r  <= (nstate_s != ST_FULL);
      out_valid_r <= (nstate_s != ST_EMPTY);
      if (load_new_s) begin
        out_r <= nxt_s;
      end else if (load_skid_out_s) begin
        out_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= nxt_s;
      end
      if (acc_s) begin
        vlan_r <= in_phv[VLAN_LSB+11 -: 12];
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_6b_a  = out_r.a6;
  assign out_6b_b  = out_r.b6;
  assign out_4b_a  = out_r.a4;
  assign out_4b_b  = out_r.b4;
  assign out_4b_c  = out_r.c4;
  assign out_2b_a  = out_r.a2;
  assign out_2b_b  = out_r.b2;
  assign out_meta  = out_r.meta;
  assign out_act   = out_r.act;
  assign vlan_id   = vlan_r;

`ifdef XBAR_IDX_ERR_EN
  function automatic logic oor(input logic [2:0] idx, input int n);
    return (32'(idx) >= 32'(n));
  endfunction

  logic        err_s;
  logic        out_err_r;
  logic        skid_err_r;
  logic [15:0] err_cnt_r;

  // Flag any index that an opcode actually consumes and that points past the populated containers
  always_comb begin
    logic [ACT_LEN-1:0] s;
    err_s = 1'b0;
    s     = '0;
    for (int i = 0; i < NUM_6B; i++) begin
      s = in_act[(S6+i)*ACT_LEN +: ACT_LEN];
      case (s[24:21])
        4'b0001, 4'b0010: err_s = err_s | oor(s[18:16], NUM_6B) | oor(s[13:11], NUM_6B);
        4'b1001, 4'b1010: err_s = err_s | oor(s[18:16], NUM_6B);
        default:          err_s = err_s;
      endcase
    end
    for (int i = 0; i < NUM_4B; i++) begin
      s = in_act[(S4+i)*ACT_LEN +: ACT_LEN];
      case (s[24:21])
        4'b0001, 4'b0010, 4'b1011, 4'b1000, 4'b0111:
                          err_s = err_s | oor(s[18:16], NUM_4B) | oor(s[13:11], NUM_4B);
        4'b1001, 4'b1010: err_s = err_s | oor(s[18:16], NUM_4B);
        default:          err_s = err_s;
      endcase
    end
    for (int i = 0; i < NUM_2B; i++) begin
      s = in_act[(S2+i)*ACT_LEN +: ACT_LEN];
      case (s[24:21])
        4'b0001, 4'b0010: err_s = err_s | oor(s[18:16], NUM_2B) | oor(s[13:11], NUM_2B);
        4'b1001, 4'b1010: err_s = err_s | oor(s[18:16], NUM_2B);
        default:          err_s = err_s;
      endcase
    end
  end

  // Error flag rides with its bundle; counter saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_err_r  <= 1'b0;
      skid_err_r <= 1'b0;
      err_cnt_r  <= 16'd0;
    end else begin
      if (load_new_s) begin
        out_err_r <= err_s;
      end else if (load_skid_out_s) begin
        out_err_r <= skid_err_r;
      end
      if (load_skid_s) begin
        skid_err_r <= err_s;
      end
      if (acc_s && err_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign idx_err_cnt = err_cnt_r;
  assign idx_err     = out_err_r & out_valid_r;
`endif

endmodule

// File: tb/tb_rmt_xbar_pipe.sv
// Directed self-checking bench for rmt_xbar_pipe (NUM_2B = 6 so idx 5 is in range and idx 6/7 are not).
module tb_rmt_xbar_pipe;
  localparam int NUM_6B  = 8;
  localparam int NUM_4B  = 8;
  localparam int NUM_2B  = 6;
  localparam int PHV_LEN = NUM_6B*48 + NUM_4B*32 + NUM_2B*16 + 256;
  localparam int NUM_ACT = NUM_6B + NUM_4B + NUM_2B + 1;
  localparam int ALEN    = NUM_ACT*25;

  logic                  clk;
  logic                  rst_n;
  logic [PHV_LEN-1:0]    in_phv;
  logic [ALEN-1:0]       in_act;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_6B*48-1:0]  out_6b_a, out_6b_b;
  logic [NUM_4B*32-1:0]  out_4b_a, out_4b_b, out_4b_c;
  logic [NUM_2B*16-1:0]  out_2b_a, out_2b_b;
  logic [255:0]          out_meta;
  logic [ALEN-1:0]       out_act;
  logic [11:0]           vlan_id;
`ifdef XBAR_IDX_ERR_EN
  logic [15:0]           idx_err_cnt;
  logic [0:0]            idx_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [ALEN-1:0] act1, act2;

  rmt_xbar_pipe #(.NUM_6B(NUM_6B), .NUM_4B(NUM_4B), .NUM_2B(NUM_2B)) dut (
    .clk(clk), .rst_n(rst_n), .in_phv(in_phv), .in_act(in_act),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_6b_a(out_6b_a), .out_6b_b(out_6b_b),
    .out_4b_a(out_4b_a), .out_4b_b(out_4b_b), .out_4b_c(out_4b_c),
    .out_2b_a(out_2b_a), .out_2b_b(out_2b_b),
    .out_meta(out_meta), .out_act(out_act), .vlan_id(vlan_id)
`ifdef XBAR_IDX_ERR_EN
    , .idx_err_cnt(idx_err_cnt), .idx_err(idx_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Containers encode {tag, index} so every selection is recognisable.
  function automatic logic [PHV_LEN-1:0] mk_phv(input logic [7:0] tag);
    logic [PHV_LEN-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_6B; i++) p[608 + i*48 +: 48] = {8'h66, tag, 24'h000000, 8'(i)};
    for (int i = 0; i < NUM_4B; i++) p[352 + i*32 +: 32] = {8'h44, tag, 8'h00, 8'(i)};
    for (int i = 0; i < NUM_2B; i++) p[256 + i*16 +: 16] = {4'h2, tag[3:0], 8'(i)};
    p[140:129] = {4'h0, tag};
    p[7:0]     = tag;
    return p;
  endfunction

  function automatic logic [24:0] mk_slot(input logic [3:0] op, input logic [2:0] ia, input logic [15:0] imm);
    return {op, 2'b00, ia, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] tag);
    in_phv   = mk_phv(tag);
    in_act   = '0;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_phv = '0; in_act = '0;
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_vlan", 64'(vlan_id), 64'd0);
    chk("rst_6b_a0", 64'(out_6b_a[47:0]), 64'd0);
`ifdef XBAR_IDX_ERR_EN
    chk("rst_err_cnt", 64'(idx_err_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Bundle 1: register pairs, immediates, out-of-range index
    act1 = '0;
    act1[4*25  +: 25] = mk_slot(4'b0001, 3'd5, {2'b00, 3'd2, 11'd0});
    act1[5*25  +: 25] = mk_slot(4'b1001, 3'd6, 16'h1234);
    act1[6*25  +: 25] = mk_slot(4'b0010, 3'd5, {2'b00, 3'd7, 11'd0});
    act1[13*25 +: 25] = mk_slot(4'b1110, 3'd0, 16'h0042);
    act1[15*25 +: 25] = mk_slot(4'b1001, 3'd7, 16'hBEEF);
    in_phv = mk_phv(8'h01); in_act = act1; in_valid = 1'b1;
    step();
    chk("b1_out_valid", 64'(out_valid), 64'd1);
    chk("b1_in_ready", 64'(in_ready), 64'd1);
    chk("b1_2b3_a", 64'(out_2b_a[3*16 +: 16]), 64'h2105);
    chk("b1_2b3_b", 64'(out_2b_b[3*16 +: 16]), 64'h2102);
    chk("b1_2b4_a_oor", 64'(out_2b_a[4*16 +: 16]), 64'h0);
    chk("b1_2b4_b_imm", 64'(out_2b_b[4*16 +: 16]), 64'h1234);
    chk("b1_2b5_a", 64'(out_2b_a[5*16 +: 16]), 64'h2105);
    chk("b1_2b5_b_oor", 64'(out_2b_b[5*16 +: 16]), 64'h0);
    chk("b1_2b0_a", 64'(out_2b_a[15:0]), 64'h2100);
    chk("b1_6b0_a", 64'(out_6b_a[47:0]), 64'h6601_0000_0007);
    chk("b1_6b0_b", 64'(out_6b_b[47:0]), 64'h0000_0000_BEEF);
    chk("b1_4b6_a", 64'(out_4b_a[6*32 +: 32]), 64'h0);
    chk("b1_4b6_b", 64'(out_4b_b[6*32 +: 32]), 64'h42);
    chk("b1_4b6_c", 64'(out_4b_c[6*32 +: 32]), 64'h4401_0006);
    chk("b1_4b0_a", 64'(out_4b_a[31:0]), 64'h4401_0000);
    chk("b1_vlan", 64'(vlan_id), 64'h001);
    chk("b1_meta", 64'(out_meta[7:0]), 64'h01);
    checks++;
    assert (out_act === act1) else begin
      errors++;
      $error("FAIL b1_act: observed %0h expected %0h", out_act, act1);
    end
`ifdef XBAR_IDX_ERR_EN
    chk("b1_err_cnt", 64'(idx_err_cnt), 64'd1);
    chk("b1_idx_err", 64'(idx_err), 64'd1);
`endif

    // Bundle 2 while bundle 1 drains: 4B-only ops, passthrough, MSB slot
    act2 = '0;
    act2[2*25  +: 25] = mk_slot(4'b1011, 3'd3, 16'h0000);
    act2[8*25  +: 25] = mk_slot(4'b1011, 3'd3, {2'b00, 3'd0, 11'd0});
    act2[14*25 +: 25] = mk_slot(4'b1010, 3'd7, 16'h8001);
    act2[22*25 +: 25] = mk_slot(4'b1110, 3'd0, 16'hFFFF);
    in_phv = mk_phv(8'h02); in_act = act2;
    step();
    chk("b2_out_valid", 64'(out_valid), 64'd1);
    chk("b2_4b6_a", 64'(out_4b_a[6*32 +: 32]), 64'h4402_0006);
    chk("b2_4b6_b", 64'(out_4b_b[6*32 +: 32]), 64'h0);
    chk("b2_4b1_a", 64'(out_4b_a[1*32 +: 32]), 64'h4402_0003);
    chk("b2_4b1_b", 64'(out_4b_b[1*32 +: 32]), 64'h4402_0000);
    chk("b2_4b7_a", 64'(out_4b_a[7*32 +: 32]), 64'h4402_0007);
    chk("b2_4b7_b", 64'(out_4b_b[7*32 +: 32]), 64'h0000_8001);
    chk("b2_2b1_a", 64'(out_2b_a[1*16 +: 16]), 64'h2201);
    chk("b2_2b1_b", 64'(out_2b_b[1*16 +: 16]), 64'h0);
    chk("b2_6b7_a", 64'(out_6b_a[7*48 +: 48]), 64'h0);
    chk("b2_6b7_b", 64'(out_6b_b[7*48 +: 48]), 64'h0000_0000_FFFF);
`ifdef XBAR_IDX_ERR_EN
    chk("b2_err_cnt", 64'(idx_err_cnt), 64'd1);
    chk("b2_idx_err", 64'(idx_err), 64'd0);
`endif
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Backpressure with three back-to-back bundles
    out_ready = 1'b0;
    send(8'h03); step();
    chk("bp1_out_valid", 64'(out_valid), 64'd1);
    chk("bp1_in_ready", 64'(in_ready), 64'd1);
    chk("bp1_data", 64'(out_2b_a[15:0]), 64'h2300);
    send(8'h04); step();
    chk("bp2_in_ready", 64'(in_ready), 64'd0);
    chk("bp2_data_hold", 64'(out_2b_a[15:0]), 64'h2300);
    send(8'h05); step();
    chk("bp3_in_ready", 64'(in_ready), 64'd0);
    chk("bp3_data_hold", 64'(out_meta[7:0]), 64'h03);
    chk("bp3_vlan", 64'(vlan_id), 64'h004);
    out_ready = 1'b1;
    step();
    chk("rel1_data", 64'(out_2b_a[15:0]), 64'h2400);
    chk("rel1_in_ready", 64'(in_ready), 64'd1);
    chk("rel1_out_valid", 64'(out_valid), 64'd1);
    step();
    chk("rel2_data", 64'(out_meta[7:0]), 64'h05);
    chk("rel2_vlan", 64'(vlan_id), 64'h005);
    in_valid = 1'b0;
    step();
    chk("rel3_out_valid", 64'(out_valid), 64'd0);
    chk("rel3_data_hold", 64'(out_meta[7:0]), 64'h05);

    // Reset while FULL drops both buffered bundles
    out_ready = 1'b0;
    send(8'h06); step();
    send(8'h07); step();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_vlan", 64'(vlan_id), 64'd0);
    chk("mrst_meta", 64'(out_meta[7:0]), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    chk("post_rst_quiet", 64'(out_valid), 64'd0);
    send(8'h08); step();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", 64'(out_meta[7:0]), 64'h08);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
